change_dispenser: RTL and testbench

Pays out a change amount in cents as a sequence of physical coins through a request/acknowledge handshake with the coin hopper. It sits downstream of the vending machine's change calculation, which produces an amount; this block turns that amount back into coins. Coin selection is greedy, largest coin first, and skips any denomination the hopper flags as empty. Any amount that cannot be paid out, or that times out, is reported as a shortfall.

---
 rtl/change_dispenser_if.sv | 25 ++
 rtl/change_dispenser.sv | 121 ++++++++++++
 tb/tb_change_dispenser.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/change_dispenser_if.sv
// Handshake bundle between the change source, the dispenser and the coin hopper.
// The dispenser takes the slave modport and the stimulus side takes the master modport.
interface change_dispenser_if;
    logic       start;
    logic [8:0] amount;
    logic [4:0] coinEmpty;
    logic       coinAck;
    logic       coinReq;
    logic [2:0] coinType;
    logic       busy;
    logic       done;
    logic       error;
    logic [8:0] shortfall;
    logic [7:0] coinCount;

    modport master (
        output start, amount, coinEmpty, coinAck,
        input  coinReq, coinType, busy, done, error, shortfall, coinCount
    );

    modport slave (
        input  start, amount, coinEmpty, coinAck,
        output coinReq, coinType, busy, done, error, shortfall, coinCount
    );
endinterface

// File: rtl/change_dispenser.sv
// Pays out a change amount as coins, largest denomination first, skipping empty hopper tubes.
// Unpayable remainders and hopper timeouts are reported as a shortfall.
module change_dispenser #(
    parameter int unsigned MAX_AMOUNT  = 500,
    parameter int unsigned ACK_TIMEOUT = 1000
) (
    input logic               clk,
    input logic               reset,
    change_dispenser_if.slave bus
);
    localparam int unsigned TimerW = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [TimerW-1:0] TimerLast = TimerW'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StSelect, StReq, StDone} state_e;

    state_e            state_q, state_d;
    logic [8:0]        remaining_q, remaining_d;
    logic [7:0]        count_q, count_d;
    logic [2:0]        type_q, type_d;
    logic [TimerW-1:0] timer_q, timer_d;
    logic [8:0]        shortfall_q;
    logic              error_q;

    logic       in_range;
    logic       found;
    logic [2:0] pick;

    function automatic logic [8:0] coin_value(input logic [2:0] idx);
        case (idx)
            3'd0:    return 9'd5;
            3'd1:    return 9'd10;
            3'd2:    return 9'd25;
            3'd3:    return 9'd50;
            default: return 9'd100;
        endcase
    endfunction

    assign in_range = 32'(bus.amount) <= MAX_AMOUNT;

    // Ascending scan: the last qualifying denomination is the largest one.
    always_comb begin
        found = 1'b0;
        pick  = 3'd0;
        for (int i = 0; i < 5; i++) begin
            if (!bus.coinEmpty[i] && coin_value(3'(i)) <= remaining_q) begin
                found = 1'b1;
                pick  = 3'(i);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        count_d     = count_q;
        type_d      = type_q;
        timer_d     = timer_q;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    remaining_d = bus.amount;
                    count_d     = '0;
                    state_d     = in_range ? StSelect : StDone;
                end
            end
            StSelect: begin
                timer_d = '0;
                if (remaining_q == '0 || !found) begin
                    state_d = StDone;
                end else begin
                    type_d  = pick;
                    state_d = StReq;
                end
            end
            StReq: begin
                if (bus.coinAck) begin
                    remaining_d = remaining_q - coin_value(type_q);
                    count_d     = count_q + 8'd1;
                    state_d     = StSelect;
                end else if (timer_q == TimerLast) begin
                    state_d = StDone;
                end else begin
                    timer_d = timer_q + TimerW'(1);
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            remaining_q <= '0;
            count_q     <= '0;
            type_q      <= '0;
            timer_q     <= '0;
            shortfall_q <= '0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            count_q     <= count_d;
            type_q      <= type_d;
            timer_q     <= timer_d;
            // Result is captured on DONE entry so it is valid alongside the done pulse.
            if (state_d == StDone) begin
                shortfall_q <= remaining_d;
                error_q     <= (remaining_d != '0);
            end
        end
    end

    assign bus.coinReq   = (state_q == StReq);
    assign bus.coinType  = type_q;
    assign bus.busy      = (state_q != StIdle);
    assign bus.done      = (state_q == StDone);
    assign bus.error     = error_q;
    assign bus.shortfall = shortfall_q;
    assign bus.coinCount = count_q;
endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: directed vector table, reset corner cases and random payouts
// checked against a greedy arithmetic model of the coin selection.
module tb_change_dispenser;
    localparam int Timeout = 8;
    localparam int Budget  = 1000;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    change_dispenser_if bus ();

    change_dispenser #(
        .MAX_AMOUNT (500),
        .ACK_TIMEOUT(Timeout)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int errors = 0;
    int checks = 0;

    int delays [0:127];
    int got_types[$];
    int got_done, got_req, got_short, got_err, got_cnt;
    int exp_types[$];
    int exp_done, exp_req, exp_short, exp_err, exp_cnt;

    typedef struct {
        int          amount;
        logic [4:0]  empty;
        bit          hold;
        bit          never;
        int          poke;
        logic [14:0] seq;
        int          seq_len;
        int          cnt;
        int          short_c;
        int          err;
        int          done_cyc;
    } vec_t;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // Greedy payout computed directly from coin values and hopper response delays.
    function automatic void model(input int amt, input logic [4:0] empty);
        int vals[5] = '{5, 10, 25, 50, 100};
        int rem, sel, pick, d;
        exp_types.delete();
        exp_req = 0;
        if (amt > 500) begin
            exp_short = amt; exp_cnt = 0; exp_err = 1; exp_done = 1;
            return;
        end
        rem = amt;
        sel = 1;
        while (1) begin
            pick = -1;
            for (int i = 0; i < 5; i++) if (!empty[i] && vals[i] <= rem) pick = i;
            if (pick < 0) begin
                exp_done = sel + 1;
                break;
            end
            d = delays[exp_types.size()];
            if (d >= Timeout) begin
                exp_req += Timeout;
                exp_done = sel + Timeout + 1;
                break;
            end
            exp_req += d + 1;
            sel += d + 2;
            rem -= vals[pick];
            exp_types.push_back(pick);
        end
        exp_short = rem;
        exp_cnt = exp_types.size();
        exp_err = (rem != 0) ? 1 : 0;
    endfunction

    // Drives one payout and plays the hopper; results land in the got_* variables.
    task automatic run_payout(input int amt, input logic [4:0] empty, input bit hold,
                              input int poke);
        int cyc, req_run, k;
        bit prev_req, busy_ok, stable_ok, ack;
        logic [2:0] held;
        got_types.delete();
        got_req = 0; k = 0; req_run = 0; prev_req = 0; busy_ok = 1; stable_ok = 1; held = '0;
        bus.amount = 9'(amt);
        bus.coinEmpty = empty;
        bus.start = 1'b1;
        @(posedge clk); #1;
        cyc = 1;
        while (cyc <= Budget && !bus.done) begin
            bus.start = (cyc == poke);
            if (cyc == poke) bus.amount = 9'd501;
            if (!bus.busy) busy_ok = 0;
            ack = hold;
            if (bus.coinReq) begin
                if (!prev_req) begin
                    req_run = 0;
                    held = bus.coinType;
                end else if (bus.coinType != held) begin
                    stable_ok = 0;
                end
                got_req++;
                if (req_run == delays[k]) ack = 1;
                if (ack) begin
                    got_types.push_back(int'(bus.coinType));
                    k++;
                end
                req_run++;
            end
            bus.coinAck = ack;
            prev_req = bus.coinReq;
            @(posedge clk); #1;
            cyc++;
        end
        bus.start = 1'b0;
        bus.coinAck = 1'b0;
        if (cyc > Budget) begin
            checks++;
            errors++;
            $display("FAIL done_wait: no done within %0d cycles, required a done pulse", Budget);
            $display("Result: errors=%0d of %0d checks", errors, checks);
            $fatal(1, "payout stalled");
        end
        got_done = cyc;
        got_short = int'(bus.shortfall);
        got_err = int'(bus.error);
        got_cnt = int'(bus.coinCount);
        check("busy_during_payout", int'(busy_ok), 1);
        check("coinType_stable_in_req", int'(stable_ok), 1);
        @(posedge clk); #1;
        check("done_single_cycle", int'(bus.done), 0);
        check("busy_after_done", int'(bus.busy), 0);
        check("shortfall_hold", int'(bus.shortfall), got_short);
    endtask

    vec_t vecs[$];

    initial begin
        reset = 1'b1;
        bus.start = 1'b0;
        bus.amount = '0;
        bus.coinEmpty = '0;
        bus.coinAck = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_coinReq", int'(bus.coinReq), 0);
        check("rst_coinType", int'(bus.coinType), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_error", int'(bus.error), 0);
        check("rst_shortfall", int'(bus.shortfall), 0);
        check("rst_coinCount", int'(bus.coinCount), 0);
        reset = 1'b0;
        @(posedge clk); #1;

        //           amt  empty     hold never poke seq                                  len cnt sh  err done
        vecs.push_back('{40,  5'b00000, 0, 0, 0, {3'd0, 3'd0, 3'd0, 3'd1, 3'd2}, 3, 3, 0, 0, 8});
        vecs.push_back('{75,  5'b00100, 0, 0, 0, {3'd0, 3'd0, 3'd1, 3'd1, 3'd3}, 4, 4, 0, 0, 10});
        vecs.push_back('{30,  5'b00011, 0, 0, 0, {12'd0, 3'd2}, 1, 1, 5, 1, 4});
        vecs.push_back('{100, 5'b00000, 0, 1, 0, 15'd0, 0, 0, 100, 1, 10});
        vecs.push_back('{0,   5'b00000, 0, 0, 0, 15'd0, 0, 0, 0, 0, 2});
        vecs.push_back('{501, 5'b00000, 0, 0, 0, 15'd0, 0, 0, 501, 1, 1});
        vecs.push_back('{40,  5'b00000, 1, 0, 0, {3'd0, 3'd0, 3'd0, 3'd1, 3'd2}, 3, 3, 0, 0, 8});
        vecs.push_back('{3,   5'b00000, 0, 0, 0, 15'd0, 0, 0, 3, 1, 2});
        vecs.push_back('{500, 5'b11110, 0, 0, 0, 15'd0, -1, 100, 0, 0, 202});
        vecs.push_back('{40,  5'b00000, 0, 0, 3, {3'd0, 3'd0, 3'd0, 3'd1, 3'd2}, 3, 3, 0, 0, 8});
        vecs.push_back('{5,   5'b00001, 0, 0, 0, 15'd0, 0, 0, 5, 1, 2});
        vecs.push_back('{130, 5'b00000, 0, 0, 0, {3'd0, 3'd0, 3'd0, 3'd2, 3'd4}, 3, 3, 0, 0, 8});

        foreach (vecs[n]) begin
            for (int i = 0; i < 128; i++) delays[i] = vecs[n].never ? 100 : 0;
            run_payout(vecs[n].amount, vecs[n].empty, vecs[n].hold, vecs[n].poke);
            check($sformatf("v%0d_done_cycle", n), got_done, vecs[n].done_cyc);
            check($sformatf("v%0d_coinCount", n), got_cnt, vecs[n].cnt);
            check($sformatf("v%0d_shortfall", n), got_short, vecs[n].short_c);
            check($sformatf("v%0d_error", n), got_err, vecs[n].err);
            check($sformatf("v%0d_req_cycles", n), got_req, vecs[n].never ? Timeout : vecs[n].cnt);
            if (vecs[n].seq_len >= 0) begin
                check($sformatf("v%0d_coin_total", n), got_types.size(), vecs[n].seq_len);
                for (int i = 0; i < vecs[n].seq_len && i < got_types.size(); i++)
                    check($sformatf("v%0d_coin%0d", n, i), got_types[i],
                          int'(vecs[n].seq[3*i +: 3]));
            end
        end

        // Reset while a coin request is outstanding aborts without a done pulse.
        begin
            int w;
            bit seen_done;
            for (int i = 0; i < 128; i++) delays[i] = 100;
            bus.amount = 9'd100;
            bus.coinEmpty = '0;
            bus.start = 1'b1;
            @(posedge clk); #1;
            bus.start = 1'b0;
            w = 0;
            while (!bus.coinReq && w < 10) begin
                @(posedge clk); #1;
                w++;
            end
            check("mid_req_reached", int'(bus.coinReq), 1);
            reset = 1'b1;
            @(posedge clk); #1;
            check("mid_req_rst_coinReq", int'(bus.coinReq), 0);
            check("mid_req_rst_busy", int'(bus.busy), 0);
            check("mid_req_rst_done", int'(bus.done), 0);
            reset = 1'b0;
            seen_done = 0;
            repeat (12) begin
                @(posedge clk); #1;
                if (bus.done || bus.coinReq) seen_done = 1;
            end
            check("mid_req_no_activity_after", int'(seen_done), 0);
        end

        // Random payouts against the greedy model.
        for (int n = 0; n < 40; n++) begin
            int amt;
            logic [4:0] empty;
            amt = (n % 8 == 7) ? int'($urandom_range(501, 511)) : int'($urandom_range(0, 500));
            empty = 5'($urandom_range(0, 31));
            for (int i = 0; i < 128; i++)
                delays[i] = ($urandom_range(0, 9) == 0) ? 30 : int'($urandom_range(0, 3));
            model(amt, empty);
            run_payout(amt, empty, 1'b0, 0);
            check($sformatf("r%0d_done_cycle", n), got_done, exp_done);
            check($sformatf("r%0d_coinCount", n), got_cnt, exp_cnt);
            check($sformatf("r%0d_shortfall", n), got_short, exp_short);
            check($sformatf("r%0d_error", n), got_err, exp_err);
            check($sformatf("r%0d_req_cycles", n), got_req, exp_req);
            check($sformatf("r%0d_coin_total", n), got_types.size(), exp_types.size());
            for (int i = 0; i < exp_types.size() && i < got_types.size(); i++)
                check($sformatf("r%0d_coin%0d", n, i), got_types[i], exp_types[i]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
